stream_packetizer: RTL and testbench

- Upstream neighbour of the byte-stream TX client buffer.
- Accepts 32-bit data words, frames them into UDP-payload packets, and streams bytes into the client's s_tdata/s_tvalid/s_tready port.
- Frame layout: 4-byte header (magic, sequence), payload words MSB-first, 2-byte word-count trailer.
- At packet end, pulses pkt_done, which drives the TX client's transmit trigger (rx_ready) once the whole packet is buffered.

---
 rtl/stream_packetizer.sv | 161 ++++++++++++++++
 tb/tb_stream_packetizer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packetizer.sv
// Frames 32-bit words into byte-stream packets: 4-byte header (magic, seq),
// payload bytes MSB-first, then a 16-bit word-count trailer.
module stream_packetizer #(
    parameter int          JUMBO_DW  = 14,
    parameter int          PKT_WORDS = 64,
    parameter logic [15:0] MAGIC     = 16'h5153,
    parameter int          FLUSH_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [31:0]         w_tdata,
    input  logic                w_tvalid,
    input  logic                w_tlast,
    output logic                w_tready,
    output logic [7:0]          s_tdata,
    output logic                s_tvalid,
    input  logic                s_tready,
    output logic                pkt_done,
    output logic [JUMBO_DW-1:0] pkt_len,
    output logic [15:0]         seq
);

    localparam int IW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [2:0] {IDLE, HDR, LOAD, BYTE, TRL, DONE} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          idx_reg, idx_next;
    logic [31:0]         word_reg, word_next;
    logic [15:0]         word_cnt_reg, word_cnt_next;
    logic                last_reg, last_next;
    logic [IW-1:0]       idle_reg, idle_next;
    logic [15:0]         seq_reg, seq_next;
    logic [JUMBO_DW-1:0] pkt_len_reg, pkt_len_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            word_reg     <= '0;
            word_cnt_reg <= '0;
            last_reg     <= 1'b0;
            idle_reg     <= '0;
            seq_reg      <= '0;
            pkt_len_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            word_reg     <= word_next;
            word_cnt_reg <= word_cnt_next;
            last_reg     <= last_next;
            idle_reg     <= idle_next;
            seq_reg      <= seq_next;
            pkt_len_reg  <= pkt_len_next;
        end
    end

    // Byte index only advances on an accepted byte, so s_tdata is stable while stalled.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        word_next     = word_reg;
        word_cnt_next = word_cnt_reg;
        last_next     = last_reg;
        idle_next     = idle_reg;
        seq_next      = seq_reg;
        pkt_len_next  = pkt_len_reg;
        w_tready      = 1'b0;
        s_tvalid      = 1'b0;
        s_tdata       = 8'h00;
        pkt_done      = 1'b0;

        case (state_reg)
            IDLE: begin
                idx_next = '0;
                if (enable && w_tvalid) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                s_tvalid = 1'b1;
                case (idx_reg)
                    2'd0:    s_tdata = MAGIC[15:8];
                    2'd1:    s_tdata = MAGIC[7:0];
                    2'd2:    s_tdata = seq_reg[15:8];
                    default: s_tdata = seq_reg[7:0];
                endcase
                if (s_tready) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                w_tready = 1'b1;
                if (w_tvalid) begin
                    word_next     = w_tdata;
                    word_cnt_next = word_cnt_reg + 16'd1;
                    last_next     = w_tlast || (word_cnt_reg + 16'd1 == 16'(PKT_WORDS));
                    idle_next     = '0;
                    idx_next      = '0;
                    state_next    = BYTE;
                end else if (FLUSH_CYC != 0 && word_cnt_reg != 16'd0) begin
                    // Partial packet starved of input: close it after FLUSH_CYC idle cycles.
                    if (idle_reg == IW'(FLUSH_CYC - 1)) begin
                        idle_next  = '0;
                        idx_next   = '0;
                        state_next = TRL;
                    end else begin
                        idle_next = idle_reg + 1'b1;
                    end
                end
            end
            BYTE: begin
                s_tvalid = 1'b1;
                case (idx_reg)
                    2'd0:    s_tdata = word_reg[31:24];
                    2'd1:    s_tdata = word_reg[23:16];
                    2'd2:    s_tdata = word_reg[15:8];
                    default: s_tdata = word_reg[7:0];
                endcase
                if (s_tready) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = last_reg ? TRL : LOAD;
                    end
                end
            end
            TRL: begin
                s_tvalid = 1'b1;
                s_tdata  = idx_reg[0] ? word_cnt_reg[7:0] : word_cnt_reg[15:8];
                if (s_tready) begin
                    if (idx_reg[0]) begin
                        idx_next     = '0;
                        pkt_len_next = JUMBO_DW'(32'd6 + 32'(word_cnt_reg) * 32'd4);
                        state_next   = DONE;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                pkt_done      = 1'b1;
                seq_next      = seq_reg + 16'd1;
                word_cnt_next = '0;
                last_next     = 1'b0;
                idle_next     = '0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pkt_len = pkt_len_reg;
    assign seq     = seq_reg;

endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer: stimulus pushes expected bytes and
// packet results, a negedge monitor pops and compares them.
module tb_stream_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] w_tdata = '0;
    logic        w_tvalid = 1'b0;
    logic        w_tlast = 1'b0;
    logic        w_tready;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready = 1'b1;
    logic        pkt_done;
    logic [13:0] pkt_len;
    logic [15:0] seq;

    int total = 0;
    int bad = 0;
    int byte_count = 0;
    int done_count = 0;
    bit rnd_mode = 1'b0;

    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    logic [15:0] exp_seq_q[$];
    logic [15:0] exp_seq = 16'd0;

    stream_packetizer #(
        .JUMBO_DW (14),
        .PKT_WORDS(64),
        .MAGIC    (16'h5153),
        .FLUSH_CYC(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .w_tdata (w_tdata),
        .w_tvalid(w_tvalid),
        .w_tlast (w_tlast),
        .w_tready(w_tready),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .pkt_done(pkt_done),
        .pkt_len (pkt_len),
        .seq     (seq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 s_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: byte transfers, stall stability and packet completion.
    logic       stall = 1'b0;
    logic [7:0] stall_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                total++;
                if (!(s_tvalid && s_tdata == stall_data)) begin
                    bad++;
                    $display("FAIL hold: valid=%0b data=0x%02h required valid=1 data=0x%02h",
                             s_tvalid, s_tdata, stall_data);
                end
            end
            if (s_tvalid && s_tready) begin
                logic [7:0] e;
                total++;
                if (exp_bytes.size() == 0) begin
                    bad++;
                    $display("FAIL byte: unexpected 0x%02h with empty scoreboard", s_tdata);
                end else begin
                    e = exp_bytes.pop_front();
                    if (s_tdata != e) begin
                        bad++;
                        $display("FAIL byte[%0d]: got 0x%02h expected 0x%02h", byte_count, s_tdata, e);
                    end
                end
                byte_count++;
            end
            stall      = s_tvalid && !s_tready;
            stall_data = s_tdata;
            if (pkt_done) begin
                done_count++;
                total++;
                if (exp_len.size() == 0) begin
                    bad++;
                    $display("FAIL pkt_done: unexpected pulse, pkt_len=%0d", pkt_len);
                end else begin
                    int          l;
                    logic [15:0] s;
                    l = exp_len.pop_front();
                    s = exp_seq_q.pop_front();
                    if (int'(pkt_len) != l || seq != s) begin
                        bad++;
                        $display("FAIL pkt: pkt_len=%0d seq=%0d expected pkt_len=%0d seq=%0d",
                                 pkt_len, seq, l, s);
                    end else begin
                        $display("ok   pkt: pkt_len=%0d seq=%0d", pkt_len, seq);
                    end
                end
            end
        end
    end

    task automatic push_pkt(input int n, input logic [31:0] base);
        logic [31:0] w;
        logic [15:0] m;
        m = 16'h5153;
        exp_bytes.push_back(m[15:8]);
        exp_bytes.push_back(m[7:0]);
        exp_bytes.push_back(exp_seq[15:8]);
        exp_bytes.push_back(exp_seq[7:0]);
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            exp_bytes.push_back(w[31:24]);
            exp_bytes.push_back(w[23:16]);
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
        end
        exp_bytes.push_back(8'(n >> 8));
        exp_bytes.push_back(8'(n));
        exp_len.push_back(6 + 4 * n);
        exp_seq_q.push_back(exp_seq);
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input int tlast_at,
                              input bit drop_en);
        for (int i = 0; i < n; i++) begin
            int waited;
            w_tdata  = base + 32'(i);
            w_tvalid = 1'b1;
            w_tlast  = (i == tlast_at);
            waited   = 0;
            @(negedge clk);
            while (!w_tready && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            if (!w_tready) begin
                total++;
                bad++;
                $display("FAIL word_accept: word %0d not accepted, w_tready=0 required 1", i);
            end
            @(posedge clk);
            #1;
            if (drop_en && i == 0) enable = 1'b0;
        end
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int waited;
        waited = 0;
        while (exp_len.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, exp_bytes.size() + exp_len.size(), 0);
        check({name, "_seq"}, int'(seq), int'(exp_seq));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int quiet;
        int dc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_tvalid", int'(s_tvalid), 0);
        check("rst_w_tready", int'(w_tready), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_pkt_len", int'(pkt_len), 0);
        check("rst_seq", int'(seq), 0);
        check("rst_s_tdata", int'(s_tdata), 0);

        // 64 back-to-back words, closed by the word-count limit.
        enable = 1'b1;
        dc = done_count;
        push_pkt(64, 32'h00010203);
        send_words(64, 32'h00010203, -1, 1'b0);
        wait_done("full64");
        check("full64_done_count", done_count - dc, 1);
        check("full64_pkt_len", int'(pkt_len), 262);

        // 3 words, w_tlast on the third.
        push_pkt(3, 32'hA0B0C0D0);
        send_words(3, 32'hA0B0C0D0, 2, 1'b0);
        wait_done("tlast3");
        check("tlast3_pkt_len", int'(pkt_len), 18);

        // 64 words under random backpressure, w_tlast on the 64th word.
        rnd_mode = 1'b1;
        dc = done_count;
        push_pkt(64, 32'h00010203);
        send_words(64, 32'h00010203, 63, 1'b0);
        wait_done("bp64");
        rnd_mode = 1'b0;
        repeat (10) @(posedge clk);
        check("bp64_single_close", done_count - dc, 1);

        // Flush: 5 words then input starves.
        push_pkt(5, 32'h11223344);
        send_words(5, 32'h11223344, -1, 1'b0);
        n = 0;
        while (!w_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (w_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("flush_idle_cycles", n, 16);
        wait_done("flush5");
        check("flush5_pkt_len", int'(pkt_len), 26);

        // enable dropped after the first word: the packet still completes.
        push_pkt(4, 32'hDEADBEEF);
        send_words(4, 32'hDEADBEEF, 3, 1'b1);
        wait_done("endrop");

        // Word offered with enable low: nothing may be emitted.
        w_tdata  = 32'h5A5A5A5A;
        w_tvalid = 1'b1;
        w_tlast  = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_tvalid || w_tready) quiet++;
        end
        check("enable_low_quiet", quiet, 0);
        push_pkt(1, 32'h5A5A5A5A);
        enable = 1'b1;
        send_words(1, 32'h5A5A5A5A, 0, 1'b0);
        wait_done("one_word");
        check("one_word_pkt_len", int'(pkt_len), 10);

        // Reset in the middle of the payload bytes.
        begin
            logic [7:0] hb[6];
            int target;
            hb = '{8'h51, 8'h53, exp_seq[15:8], exp_seq[7:0], 8'hC3, 8'h3C};
            for (int i = 0; i < 6; i++) exp_bytes.push_back(hb[i]);
            target   = byte_count + 6;
            w_tdata  = 32'hC33CA55A;
            w_tvalid = 1'b1;
            w_tlast  = 1'b0;
            n = 0;
            @(negedge clk);
            while (!w_tready && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1 w_tvalid = 1'b0;
            n = 0;
            while (byte_count < target && n < 100) begin
                @(posedge clk);
                n++;
            end
            #2 rst_n = 1'b0;
            #1;
            check("mid_rst_s_tvalid", int'(s_tvalid), 0);
            check("mid_rst_w_tready", int'(w_tready), 0);
            check("mid_rst_seq", int'(seq), 0);
            exp_seq = 16'd0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check("post_rst_s_tvalid", int'(s_tvalid), 0);
            check("post_rst_bytes_left", exp_bytes.size(), 0);
        end

        push_pkt(2, 32'h01020304);
        send_words(2, 32'h01020304, 1, 1'b0);
        wait_done("after_rst");
        check("after_rst_pkt_len", int'(pkt_len), 14);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
